// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register target: command layout,
// byte width and the frame-level state encoding.
package spi_pkg;

  localparam int CMD_RW_BIT = 7;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_t;

  // True on the count value that marks the last bit of a byte
  function automatic logic isLastBit(input logic [2:0] bitCnt);
    return bitCnt == 3'(BYTE_W - 1);
  endfunction

endpackage

// File: rtl/spi_slave_regs_if.sv
// Serial pins between the SPI master and the register target.
// The master drives ss/sck/mosi; the target drives miso and its pad enable.
interface spi_slave_regs_if;

  logic ss;
  logic sck;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output ss, output sck, output mosi, input miso, input miso_oe);
  modport slave  (input ss, input sck, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with a third flop used
// only to detect rising and falling edges of the synchronized level.
// RESET_VAL selects the value the chain assumes while in reset.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  // Shift the pin through the synchronizer and the edge-history flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {3{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_rise = r_sync[1] & ~r_sync[2];
  assign o_fall = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 target with a local byte-wide register bank.
// Frame: command byte {rw, addr} then a data byte, MSB first.
// Build option: define SPI_SLAVE_AUTOINC_EN for burst mode, where every
// further byte in the frame accesses the next (wrapping) address. Without
// it, bytes after the first data byte are ignored.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  spi_slave_regs_if.slave   spi,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_stb,
  output logic              busy,
  output logic              frame_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              w_sckRise;
  logic              w_sckFall;
  logic              w_ssRise;
  logic              w_ssFall;
  logic              w_mosi;
  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_cmdAddr;
  logic [ADDR_W-1:0] w_nextAddr;

  logic [1:0]        r_mosiSync;
  spi_state_t        r_state;
  logic [2:0]        r_bitCnt;
  logic [6:0]        r_rxShift;
  logic [7:0]        r_txShift;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic              r_dataDone;
  logic              r_miso;
  logic              r_misoOe;
  logic              r_busy;
  logic              r_wrStb;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [7:0]        r_wrData;
  logic              r_rdStb;
  logic              r_frameErr;
  logic [7:0]        r_bank [DEPTH];

  // sck idles low, so its chain resets low
  spi_sync_edge #(.RESET_VAL(1'b0)) u_sckSync (
    .clk     (clk),
    .rst     (rst),
    .i_async (spi.sck),
    .o_rise  (w_sckRise),
    .o_fall  (w_sckFall)
  );

  // ss chain resets low: if ss is still low when reset releases no fall is
  // seen, so the block waits for a fresh frame; if ss is high, the rise
  // lands in IDLE and is harmless
  spi_sync_edge #(.RESET_VAL(1'b0)) u_ssSync (
    .clk     (clk),
    .rst     (rst),
    .i_async (spi.ss),
    .o_rise  (w_ssRise),
    .o_fall  (w_ssFall)
  );

  // mosi only needs synchronizing; it stays aligned with the sck chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mosiSync <= 2'b00;
    end else begin
      r_mosiSync <= {r_mosiSync[0], spi.mosi};
    end
  end

  assign w_mosi     = r_mosiSync[1];
  assign w_byte     = {r_rxShift, w_mosi};
  assign w_cmdAddr  = w_byte[ADDR_W-1:0];
  assign w_nextAddr = r_addr + ADDR_W'(1);

  // Frame FSM: shifts bits, decodes the command, owns the bank and all outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bitCnt   <= 3'd0;
      r_rxShift  <= 7'd0;
      r_txShift  <= 8'd0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_dataDone <= 1'b0;
      r_miso     <= 1'b0;
      r_misoOe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wrStb    <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= 8'd0;
      r_rdStb    <= 1'b0;
      r_frameErr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= 8'd0;
      end
    end else begin
      r_wrStb    <= 1'b0;
      r_rdStb    <= 1'b0;
      r_frameErr <= 1'b0;
      if (w_ssRise) begin
        r_frameErr <= (r_state != IDLE) && (r_bitCnt != 3'd0);
        r_state    <= IDLE;
        r_bitCnt   <= 3'd0;
        r_miso     <= 1'b0;
        r_misoOe   <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_ssFall) begin
              r_state    <= CMD;
              r_bitCnt   <= 3'd0;
              r_dataDone <= 1'b0;
              r_miso     <= 1'b0;
              r_misoOe   <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
          CMD: begin
            if (w_sckRise) begin
              r_rxShift <= w_byte[6:0];
              r_bitCnt  <= r_bitCnt + 3'd1;
              if (isLastBit(r_bitCnt)) begin
                r_rw    <= w_byte[CMD_RW_BIT];
                r_addr  <= w_cmdAddr;
                r_state <= DATA;
                if (w_byte[CMD_RW_BIT]) begin
                  r_txShift <= r_bank[w_cmdAddr];
                  r_rdStb   <= 1'b1;
                end
              end
            end
          end
          DATA: begin
            if (w_sckRise) begin
              r_rxShift <= w_byte[6:0];
              r_bitCnt  <= r_bitCnt + 3'd1;
              if (isLastBit(r_bitCnt) && !r_dataDone) begin
                if (!r_rw) begin
                  r_bank[r_addr] <= w_byte;
                  r_wrStb        <= 1'b1;
                  r_wrAddr       <= r_addr;
                  r_wrData       <= w_byte;
                end
`ifdef SPI_SLAVE_AUTOINC_EN
                r_addr <= w_nextAddr;
                if (r_rw) begin
                  r_txShift <= r_bank[w_nextAddr];
                  r_rdStb   <= 1'b1;
                end
`else
                r_dataDone <= 1'b1;
`endif
              end
            end else if (w_sckFall) begin
              if (r_rw && !r_dataDone) begin
                r_miso    <= r_txShift[7];
                r_txShift <= {r_txShift[6:0], 1'b0};
              end else begin
                r_miso <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign spi.miso    = r_miso;
  assign spi.miso_oe = r_misoOe;
  assign busy        = r_busy;
  assign wr_stb      = r_wrStb;
  assign wr_addr     = r_wrAddr;
  assign wr_data     = r_wrData;
  assign rd_stb      = r_rdStb;
  assign frame_err   = r_frameErr;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Testbench for spi_slave_regs: directed scenarios plus randomized frames,
// all checked against a frame-level model of the register bank.
// Honours SPI_SLAVE_AUTOINC_EN the same way the design does.
module tb_spi_slave_regs;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_stb;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              rd_stb;
  logic              busy;
  logic              frame_err;

  spi_slave_regs_if spiBus ();

  spi_slave_regs #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spiBus),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_stb    (rd_stb),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // observed pulse counts
  int wrCnt  = 0;
  int rdCnt  = 0;
  int errCnt = 0;

  // model state and expectations
  logic [7:0]        mBank [DEPTH];
  int                expWr  = 0;
  int                expRd  = 0;
  int                expErr = 0;
  logic [ADDR_W-1:0] expWrAddr = '0;
  logic [7:0]        expWrData = 8'h00;
  logic [7:0]        expRx [8];

  // frame buffers and per-frame observations
  logic [7:0] txBuf [8];
  logic [7:0] rxBuf [8];
  logic       oeBad;
  logic       busyAt2;
  logic       busyAt3;
  logic       oeAt3;

  // Count strobe pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (wr_stb)    wrCnt++;
    if (rd_stb)    rdCnt++;
    if (frame_err) errCnt++;
  end

  // Drive one frame of nBits bits from txBuf and capture miso into rxBuf
  task automatic applyStimulus(input int nBits, input int halfP);
    spiBus.ss = 1'b0;
    oeBad = 1'b0;
    repeat (halfP) @(negedge clk);
    for (int i = 0; i < nBits; i++) begin
      spiBus.mosi = txBuf[i / 8][7 - (i % 8)];
      repeat (halfP) @(negedge clk);
      rxBuf[i / 8][7 - (i % 8)] = spiBus.miso;
      if (spiBus.miso_oe !== 1'b1) oeBad = 1'b1;
      spiBus.sck = 1'b1;
      repeat (halfP) @(negedge clk);
      spiBus.sck = 1'b0;
    end
    repeat (halfP) @(negedge clk);
    spiBus.ss   = 1'b1;
    spiBus.mosi = 1'b0;
    repeat (2) @(negedge clk);
    busyAt2 = busy;
    @(negedge clk);
    busyAt3 = busy;
    oeAt3   = spiBus.miso_oe;
    repeat (6) @(negedge clk);
  endtask

  // Frame-level model: what a frame of nBits from txBuf does to the bank
  task automatic modelFrame(input int nBits);
    int   nFull;
    int   a;
    int   addr;
    logic rw;
    bit   active;
    nFull = nBits / 8;
    rw    = txBuf[0][7];
    a     = int'(txBuf[0][6:0]);
    for (int b = 0; b < 8; b++) expRx[b] = 8'h00;
    if (nBits % 8 != 0) expErr++;
    if (nFull >= 1 && rw) expRd++;
    for (int j = 0; j < nFull - 1; j++) begin
`ifdef SPI_SLAVE_AUTOINC_EN
      active = 1'b1;
`else
      active = (j == 0);
`endif
      addr = (a + j) % DEPTH;
      if (active) begin
        if (rw) begin
          expRx[j + 1] = mBank[addr];
`ifdef SPI_SLAVE_AUTOINC_EN
          expRd++;
`endif
        end else begin
          mBank[addr] = txBuf[j + 1];
          expWr++;
          expWrAddr = ADDR_W'(addr);
          expWrData = txBuf[j + 1];
        end
      end
    end
  endtask

  task automatic clearModel;
    for (int i = 0; i < DEPTH; i++) mBank[i] = 8'h00;
  endtask

  task automatic test_reset;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (spiBus.miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b expected 0", spiBus.miso); end
    checks++; if (spiBus.miso_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso_oe: got %b expected 0", spiBus.miso_oe); end
    checks++; if (wr_stb !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_stb: got %b expected 0", wr_stb); end
    checks++; if (rd_stb !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_stb: got %b expected 0", rd_stb); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (errCnt !== expErr) begin errors++; $display("[TB] FAIL reset_release_err: got %0d expected %0d", errCnt, expErr); end
  endtask

  task automatic test_write;
    txBuf[0] = 8'h55;
    txBuf[1] = 8'hAA;
    modelFrame(16);
    applyStimulus(16, 50);
    checks++; if (wrCnt !== expWr) begin errors++; $display("[TB] FAIL write_count: got %0d expected %0d", wrCnt, expWr); end
    checks++; if (wr_addr !== expWrAddr) begin errors++; $display("[TB] FAIL write_addr: got %h expected %h", wr_addr, expWrAddr); end
    checks++; if (wr_data !== expWrData) begin errors++; $display("[TB] FAIL write_data: got %h expected %h", wr_data, expWrData); end
    checks++; if (rdCnt !== expRd) begin errors++; $display("[TB] FAIL write_rd_count: got %0d expected %0d", rdCnt, expRd); end
    checks++; if (busyAt3 !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_end: got %b expected 0", busyAt3); end
  endtask

  task automatic test_read;
    txBuf[0] = 8'hD5;
    txBuf[1] = 8'h00;
    modelFrame(16);
    applyStimulus(16, 50);
    checks++; if (rxBuf[0] !== expRx[0]) begin errors++; $display("[TB] FAIL read_cmd_miso: got %h expected %h", rxBuf[0], expRx[0]); end
    checks++; if (rxBuf[1] !== expRx[1]) begin errors++; $display("[TB] FAIL read_data: got %h expected %h", rxBuf[1], expRx[1]); end
    checks++; if (rdCnt !== expRd) begin errors++; $display("[TB] FAIL read_rd_count: got %0d expected %0d", rdCnt, expRd); end
    checks++; if (oeBad !== 1'b0) begin errors++; $display("[TB] FAIL read_oe_in_frame: got low expected high"); end
    checks++; if (oeAt3 !== 1'b0) begin errors++; $display("[TB] FAIL read_oe_after: got %b expected 0", oeAt3); end
    checks++; if (wrCnt !== expWr) begin errors++; $display("[TB] FAIL read_wr_count: got %0d expected %0d", wrCnt, expWr); end
  endtask

  task automatic test_abort;
    txBuf[0] = 8'h55;
    txBuf[1] = 8'h33;
    modelFrame(12);
    applyStimulus(12, 50);
    checks++; if (errCnt !== expErr) begin errors++; $display("[TB] FAIL abort_err_count: got %0d expected %0d", errCnt, expErr); end
    checks++; if (wrCnt !== expWr) begin errors++; $display("[TB] FAIL abort_wr_count: got %0d expected %0d", wrCnt, expWr); end
    txBuf[0] = 8'hD5;
    modelFrame(16);
    applyStimulus(16, 20);
    checks++; if (rxBuf[1] !== expRx[1]) begin errors++; $display("[TB] FAIL abort_readback: got %h expected %h", rxBuf[1], expRx[1]); end
  endtask

  task automatic test_burst;
    txBuf[0] = 8'h7F;
    txBuf[1] = 8'h11;
    txBuf[2] = 8'h22;
    modelFrame(24);
    applyStimulus(24, 20);
    checks++; if (wrCnt !== expWr) begin errors++; $display("[TB] FAIL burst_wr_count: got %0d expected %0d", wrCnt, expWr); end
    checks++; if (wr_addr !== expWrAddr) begin errors++; $display("[TB] FAIL burst_wr_addr: got %h expected %h", wr_addr, expWrAddr); end
    checks++; if (wr_data !== expWrData) begin errors++; $display("[TB] FAIL burst_wr_data: got %h expected %h", wr_data, expWrData); end
    txBuf[0] = 8'hFF;
    modelFrame(16);
    applyStimulus(16, 20);
    checks++; if (rxBuf[1] !== expRx[1]) begin errors++; $display("[TB] FAIL burst_read_7f: got %h expected %h", rxBuf[1], expRx[1]); end
    txBuf[0] = 8'h80;
    modelFrame(16);
    applyStimulus(16, 20);
    checks++; if (rxBuf[1] !== expRx[1]) begin errors++; $display("[TB] FAIL burst_read_00: got %h expected %h", rxBuf[1], expRx[1]); end
  endtask

  task automatic test_reset_mid;
    txBuf[0] = 8'h55;
    spiBus.ss = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      spiBus.mosi = txBuf[0][7 - i];
      repeat (20) @(negedge clk);
      spiBus.sck = 1'b1;
      repeat (20) @(negedge clk);
      spiBus.sck = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (spiBus.miso_oe !== 1'b0) begin errors++; $display("[TB] FAIL midrst_miso_oe: got %b expected 0", spiBus.miso_oe); end
    checks++; if (wr_addr !== '0) begin errors++; $display("[TB] FAIL midrst_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_wr_data: got %h expected 0", wr_data); end
    clearModel();
    expWrAddr = '0;
    expWrData = 8'h00;
    repeat (5) @(negedge clk);
    spiBus.ss   = 1'b1;
    spiBus.mosi = 1'b0;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (errCnt !== expErr) begin errors++; $display("[TB] FAIL midrst_err_count: got %0d expected %0d", errCnt, expErr); end
    txBuf[0] = 8'h12;
    txBuf[1] = 8'h5A;
    modelFrame(16);
    applyStimulus(16, 16);
    checks++; if (wr_data !== expWrData) begin errors++; $display("[TB] FAIL midrst_next_wr_data: got %h expected %h", wr_data, expWrData); end
    txBuf[0] = 8'hD5;
    modelFrame(16);
    applyStimulus(16, 16);
    checks++; if (rxBuf[1] !== expRx[1]) begin errors++; $display("[TB] FAIL midrst_bank_cleared: got %h expected %h", rxBuf[1], expRx[1]); end
  endtask

  task automatic test_read_zero;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clearModel();
    expWrAddr = '0;
    expWrData = 8'h00;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    txBuf[0] = 8'h80;
    txBuf[1] = 8'hFF;
    modelFrame(16);
    applyStimulus(16, 10);
    checks++; if (rxBuf[1] !== expRx[1]) begin errors++; $display("[TB] FAIL zero_read_data: got %h expected %h", rxBuf[1], expRx[1]); end
    checks++; if (busyAt2 !== 1'b1) begin errors++; $display("[TB] FAIL zero_busy_2clk: got %b expected 1", busyAt2); end
    checks++; if (busyAt3 !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_3clk: got %b expected 0", busyAt3); end
    checks++; if (rdCnt !== expRd) begin errors++; $display("[TB] FAIL zero_rd_count: got %0d expected %0d", rdCnt, expRd); end
  endtask

  task automatic test_random;
    int halfP;
    int nData;
    int partial;
    int nBits;
    for (int f = 0; f < 30; f++) begin
      halfP   = $urandom_range(4, 10);
      nData   = $urandom_range(1, 3);
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      nBits   = 8 * (1 + nData) + partial;
      for (int b = 0; b < 8; b++) txBuf[b] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) txBuf[0][6:0] = 7'h7E;
      modelFrame(nBits);
      applyStimulus(nBits, halfP);
      for (int b = 0; b <= nData; b++) begin
        checks++;
        if (rxBuf[b] !== expRx[b]) begin
          errors++;
          $display("[TB] FAIL rand_miso frame %0d byte %0d cmd %h: got %h expected %h", f, b, txBuf[0], rxBuf[b], expRx[b]);
        end
      end
      checks++; if (wrCnt !== expWr) begin errors++; $display("[TB] FAIL rand_wr_count frame %0d: got %0d expected %0d", f, wrCnt, expWr); end
      checks++; if (rdCnt !== expRd) begin errors++; $display("[TB] FAIL rand_rd_count frame %0d: got %0d expected %0d", f, rdCnt, expRd); end
      checks++; if (errCnt !== expErr) begin errors++; $display("[TB] FAIL rand_err_count frame %0d: got %0d expected %0d", f, errCnt, expErr); end
      checks++; if (wr_addr !== expWrAddr) begin errors++; $display("[TB] FAIL rand_wr_addr frame %0d: got %h expected %h", f, wr_addr, expWrAddr); end
      checks++; if (wr_data !== expWrData) begin errors++; $display("[TB] FAIL rand_wr_data frame %0d: got %h expected %h", f, wr_data, expWrData); end
      checks++; if (oeBad !== 1'b0) begin errors++; $display("[TB] FAIL rand_oe frame %0d: got low expected high", f); end
      checks++; if (busyAt3 !== 1'b0) begin errors++; $display("[TB] FAIL rand_busy_end frame %0d: got %b expected 0", f, busyAt3); end
    end
  endtask

  initial begin
    spiBus.ss   = 1'b1;
    spiBus.sck  = 1'b0;
    spiBus.mosi = 1'b0;
    clearModel();
    $display("[TB] spi_slave_regs bench start");
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_burst();
    test_reset_mid();
    test_read_zero();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI mode-0 target that answers the team's SPI master. Decodes a command byte, then writes or reads a local byte-wide register bank. sck, ss and mosi are oversampled in the clk domain. Sits on the far end of the serial link, at the peripheral-side boundary of the design.

## Interface
Parameters:
- ADDR_W, 7: address width, legal range 1..7. Register bank depth is 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock; must be at least 8× the sck frequency.
- rst  in  1  reset, asynchronous, active-low.
- ss  in  1  slave select, active-low, asynchronous to clk.
- sck  in  1  serial clock, idle low, asynchronous to clk.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  output enable for the miso pad; high while synchronized ss is low.
- wr_stb  out  1  one-cycle pulse when a bank write commits.
- wr_addr  out  ADDR_W  address of the last committed write.
- wr_data  out  8  data of the last committed write.
- rd_stb  out  1  one-cycle pulse when a bank byte is fetched for transmit.
- busy  out  1  high while a frame is in progress.
- frame_err  out  1  one-cycle pulse when ss deasserts mid-byte.

## Operation
- Synchronization: ss, sck and mosi each pass through a 2-flop synchronizer. sck rise and fall are edge-detected against a third flop.
- Frame format: MSB first.
  - Byte 0 is the command {rw, a[6:0]}: rw=1 means read, rw=0 means write.
  - Address = a[ADDR_W-1:0]; upper address bits are ignored.
  - Byte 1 is data.
- Sampling: mosi is sampled on the sck rising edge. miso changes on the sck falling edge.
- FSM states:
  - IDLE: ss high. busy=0, miso_oe=0, miso=0.
  - ss falls → CMD. Bit counter is cleared and busy=1.
  - CMD: shift in 8 bits.
    - On the 8th rise, latch address and rw, then go to DATA.
    - If rw=1: load bank[addr] into the tx shift register and pulse rd_stb.
    - miso=0 throughout CMD.
  - DATA, write: shift in 8 bits. On the 8th rise:
    - bank[addr] is updated.
    - wr_addr/wr_data are updated.
    - wr_stb pulses.
  - DATA, read: tx MSB is driven on the first fall after the command byte, then one bit per fall.
  - Any state, ss rises → IDLE. If the bit counter ≠ 0, pulse frame_err. A partial write byte is never committed.
- Bytes after the data byte follow the Configuration rules.
- Reset values:
  - All outputs are 0.
  - Bank is all 0; FSM is IDLE.
  - Reset mid-frame aborts without commit or error pulse. After rst releases, the block waits for a fresh ss fall.

## Timing
- Pin-to-detect latency: 3 clk for sck edges and ss.
- Write commit: wr_stb is asserted in the clk cycle after the 8th data rise is detected.
  - bank readable with the new value from the next cycle.
  - wr_addr/wr_data valid with wr_stb and held until the next commit.
- Read fetch: rd_stb is asserted the cycle after the 8th command rise is detected.
  - miso MSB valid 1 clk after the following sck fall is detected.
  - This is the reason for the 8× clk requirement.
- frame_err: pulses 1 cycle after the ss rise is detected.
- Simultaneous ss rise and 8th sck rise detection: ss wins; no commit.

## Configuration
- Macro SPI_SLAVE_AUTOINC_EN.
- Defined (burst mode):
  - After each data byte, the address increments, wrapping 2^ADDR_W−1 → 0.
  - Further bytes in the same frame write or read successive addresses.
  - Reads prefetch the next byte on the 8th rise of the current byte and pulse rd_stb.
- Undefined:
  - Bytes after the first data byte are ignored; no commit.
  - miso=0 for those bytes.

## Structure
- Shared package spi_pkg holds:
  - CMD_RW_BIT=7.
  - FSM state encoding IDLE/CMD/DATA.
  - Byte width 8.
- Sub-module spi_sync_edge: 2-flop synchronizer plus rise/fall detector, instantiated for sck and ss. mosi uses the synchronizer only.
- Register bank stays inline as an array.

## Test plan
- Write 0x55 at sck = clk/100, ADDR_W=7, cmd 0x55, data 0xAA: one wr_stb, wr_addr=0x55, wr_data=0xAA, bank[0x55]=0xAA.
- Read back cmd 0xD5: rd_stb once; miso shifts 1010_1010 on successive falls; miso_oe high only while ss low.
- Abort: ss raised after 4 bits of a write data byte → frame_err pulse, no wr_stb, bank unchanged.
- Burst (macro defined): cmd 0x7F followed by 0x11, 0x22 → bank[0x7F]=0x11, bank[0x00]=0x22, two wr_stb. Macro undefined: only bank[0x7F] written.
- rst asserted mid-command byte: all outputs 0 immediately. The next full frame works normally.
- Fresh reset, read cmd 0x80: miso=0x00 for all 8 bits, busy deasserts 3 clk after ss rises.
